// File: rtl/div_bcd_pkg.sv
// Shared types and constants for the division-result BCD converter.
// Optional feature macro: DIV_BCD_ZERO_BLANK_EN (leading-zero blanking).
package div_bcd_pkg;

    // Conversion sequence: quotient first, then remainder, then hold for readout.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_Q = 2'd1,
        CONV_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Nibble shown in place of a suppressed leading zero.
    localparam logic [3:0] BLANK_NIBBLE = 4'hF;

    // Digits at or above this value get +3 before the shift (double dabble).
    localparam logic [3:0] ADD3_THRESH  = 4'd5;

endpackage : div_bcd_pkg

// File: rtl/bcd_add3_shift.sv
// One double-dabble step: add 3 to every BCD digit >= 5, then shift the
// whole {bcd, bin} accumulator left by one bit. Purely combinational.
module bcd_add3_shift
    import div_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS+WIDTH-1:0] acc_i,
    output logic [4*DIGITS+WIDTH-1:0] acc_o
);

    localparam int ACC_W = 4*DIGITS + WIDTH;

    logic [ACC_W-1:0] adj;

    // Adjust each digit that would overflow past 9 when doubled, then shift.
    always_comb begin
        // NOTE: every combinational output gets a full default before any
        // conditional update, so no path leaves it unassigned (no latch).
        adj = acc_i;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_i[WIDTH+4*d +: 4] >= ADD3_THRESH) begin
                adj[WIDTH+4*d +: 4] = acc_i[WIDTH+4*d +: 4] + 4'd3;
            end
        end
        acc_o = {adj[ACC_W-2:0], 1'b0};
    end

endmodule : bcd_add3_shift

// File: rtl/div_result_bcd.sv
// Converts one quotient/remainder pair from the divider into packed BCD,
// one bit per cycle on a shared double-dabble datapath, quotient first.
// Results are presented to the readout stage over a valid/ready handshake.
// Optional feature macro: DIV_BCD_ZERO_BLANK_EN -- when defined, leading zero
// digits (never digit 0) are replaced by BLANK_NIBBLE as results are stored.
module div_result_bcd
    import div_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    quotient,
    input  logic [WIDTH-1:0]    remainder,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] q_bcd,
    output logic [4*DIGITS-1:0] r_bcd,
    output logic                busy
);

    localparam int BCD_W = 4*DIGITS;
    localparam int ACC_W = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic [BCD_W-1:0] q_bcd_q, q_bcd_d;
    logic [BCD_W-1:0] r_bcd_q, r_bcd_d;
    logic [ACC_W-1:0] acc_step;
    logic             last_iter;

`ifdef DIV_BCD_ZERO_BLANK_EN
    // Replace leading zero digits (scanning down from the MSD) with the blank code.
    function automatic logic [BCD_W-1:0] fmt_out(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = v;
        lead = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && (v[4*d +: 4] == 4'd0)) begin
                r[4*d +: 4] = BLANK_NIBBLE;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`else
    // Plain BCD with leading zeros kept.
    function automatic logic [BCD_W-1:0] fmt_out(input logic [BCD_W-1:0] v);
        return v;
    endfunction
`endif

    bcd_add3_shift #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .acc_i (acc_q),
        .acc_o (acc_step)
    );

    assign last_iter = (cnt_q == LAST_ITER);

    // State and datapath registers; reset clears everything, including a partial result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            q_bcd_q <= '0;
            r_bcd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            q_bcd_q <= q_bcd_d;
            r_bcd_q <= r_bcd_d;
        end
    end

    // Next-state: accept in IDLE, WIDTH iterations per operand, hold DONE until taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = CONV_Q;
            CONV_Q:  if (last_iter) state_d = CONV_R;
            CONV_R:  if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Datapath: load operands, iterate, and store each finished result.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        q_bcd_d = q_bcd_q;
        r_bcd_d = r_bcd_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d = {{BCD_W{1'b0}}, quotient};
                    rem_d = remainder;
                    cnt_d = '0;
                end
            end
            CONV_Q: begin
                if (last_iter) begin
                    // Final shift lands directly in q_bcd; reload with the remainder.
                    q_bcd_d = fmt_out(acc_step[ACC_W-1 -: BCD_W]);
                    acc_d   = {{BCD_W{1'b0}}, rem_q};
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CONV_R: begin
                if (last_iter) begin
                    r_bcd_d = fmt_out(acc_step[ACC_W-1 -: BCD_W]);
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == CONV_Q) || (state_q == CONV_R);
        out_valid = (state_q == DONE);
    end

    assign q_bcd = q_bcd_q;
    assign r_bcd = r_bcd_q;

endmodule : div_result_bcd
